// File: rtl/ahblite_bram_ctrl.sv
// ahblite_bram_ctrl
// AHB-Lite slave that maps a 32-bit bus onto a simple dual-port block RAM
// (one read port, one byte-strobed write port).
//
// Ports
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HSEL .. HREADY          AHB-Lite slave inputs (HPROT is ignored)
//   HREADYOUT, HRDATA, HRESP AHB-Lite slave outputs
//   BRAM_RDADDR/RDEN/RDATA  BRAM read port, data returns RD_LATENCY cycles later
//   BRAM_WRADDR/WDATA/WRITE BRAM write port with per-byte strobes
//
// Handshake: a transfer is accepted in the cycle where HSEL, HTRANS[1]
// (NONSEQ/SEQ) and HREADY are all high; the following cycle(s) form its data
// phase, which ends in the cycle where HREADYOUT is high. Nothing on the
// address-phase inputs is looked at while HREADY is low.
//
// Writes are zero-wait: the address and strobes are captured in the address
// phase and the BRAM write fires in the first data-phase cycle with HWDATA.
// Reads issue to the BRAM in the address phase; RD_LATENCY=2 adds one wait
// state. A read whose address phase overlaps the data phase of a write to the
// same word takes the written bytes from HWDATA instead of the BRAM, since the
// BRAM has not yet been written when the read is issued.
module ahblite_bram_ctrl #(
    parameter int ADDR_WIDTH    = 14,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_UNALIGNED = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
    output logic                  BRAM_RDEN,
    input  logic [31:0]           BRAM_RDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WRITE
);

    localparam bit LAT2   = (RD_LATENCY == 2);
    localparam bit ERR_EN = (ERR_UNALIGNED != 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RWAIT = 2'd1;
    localparam logic [1:0] S_ERR1  = 2'd2;
    localparam logic [1:0] S_ERR2  = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic                  wr_pend_q,  wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
    logic [3:0]            wr_strb_q,  wr_strb_d;
    logic [3:0]            fwd_strb_q, fwd_strb_d;
    logic [31:0]           fwd_data_q, fwd_data_d;

    logic                  accept;
    logic                  legal;
    logic                  rd_go;
    logic                  wr_go;
    logic                  hazard;
    logic [3:0]            strb;
    logic [ADDR_WIDTH-1:0] word_addr;

    // HPROT, HTRANS[0] and the address bits above the BRAM are not decoded.
    logic unused_ok;
    assign unused_ok = ^{HPROT, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign word_addr = HADDR[ADDR_WIDTH+1:2];
    assign accept    = HSEL & HTRANS[1] & HREADY;

    // Size/alignment decode into byte strobes; anything not listed is illegal.
    always_comb begin
        strb  = 4'b0000;
        legal = 1'b0;
        case (HSIZE)
            3'd0: begin
                legal = 1'b1;
                strb  = 4'b0001 << HADDR[1:0];
            end
            3'd1: begin
                legal = ~HADDR[0];
                strb  = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal = (HADDR[1:0] == 2'b00);
                strb  = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                strb  = 4'b0000;
            end
        endcase
    end

    assign rd_go  = accept & legal & ~HWRITE;
    assign wr_go  = accept & legal & HWRITE;
    // wr_pend_q marks the cycle in which HWDATA belongs to the previous write.
    assign hazard = rd_go & wr_pend_q & (word_addr == wr_addr_q);

    always_comb begin
        wr_pend_d  = wr_go;
        wr_addr_d  = wr_go ? word_addr : wr_addr_q;
        wr_strb_d  = wr_go ? strb : wr_strb_q;
        fwd_strb_d = 4'b0000;
        fwd_data_d = fwd_data_q;
        if (rd_go) begin
            fwd_strb_d = hazard ? wr_strb_q : 4'b0000;
            fwd_data_d = HWDATA;
        end else if (state_q == S_RWAIT) begin
            // Keep the forwarded bytes until the read's final data cycle.
            fwd_strb_d = fwd_strb_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RWAIT: state_d = S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            default: begin
                // IDLE and ERR2 both have HREADYOUT high, so a transfer can be
                // accepted in either; it is decoded identically in both.
                state_d = S_IDLE;
                if (accept & ~legal & ERR_EN) begin
                    state_d = S_ERR1;
                end else if (rd_go & LAT2) begin
                    state_d = S_RWAIT;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            wr_pend_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_strb_q  <= 4'b0000;
            fwd_strb_q <= 4'b0000;
            fwd_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            wr_pend_q  <= wr_pend_d;
            wr_addr_q  <= wr_addr_d;
            wr_strb_q  <= wr_strb_d;
            fwd_strb_q <= fwd_strb_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign HREADYOUT = ~((state_q == S_RWAIT) | (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) | (state_q == S_ERR2);

    assign BRAM_RDADDR = word_addr;
    // Gated by reset so the read enable drops the moment reset is asserted.
    assign BRAM_RDEN   = HRESETn & rd_go;
    assign BRAM_WRADDR = wr_addr_q;
    assign BRAM_WDATA  = HWDATA;
    assign BRAM_WRITE  = wr_pend_q ? wr_strb_q : 4'b0000;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            HRDATA[8*i +: 8] = fwd_strb_q[i] ? fwd_data_q[8*i +: 8] : BRAM_RDATA[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
// Bench for ahblite_bram_ctrl: instance 0 uses RD_LATENCY=1, ERR_UNALIGNED=1;
// instance 1 uses RD_LATENCY=2, ERR_UNALIGNED=0. Each has its own BRAM model.
// The reference is a word array updated with the bytes each completed legal
// write covers; reads must return it, whatever the pipeline timing.
module tb_ahblite_bram_ctrl;
    localparam int AW = 8;

    logic hclk = 1'b0;
    logic hresetn;
    always #5 hclk = ~hclk;

    logic        hsel        [2];
    logic [31:0] haddr       [2];
    logic [1:0]  htrans      [2];
    logic [2:0]  hsize       [2];
    logic [3:0]  hprot       [2];
    logic        hwrite      [2];
    logic [31:0] hwdata      [2];
    logic        hready      [2];
    logic        hreadyout   [2];
    logic [31:0] hrdata      [2];
    logic        hresp       [2];
    logic [AW-1:0] bram_rdaddr [2];
    logic        bram_rden   [2];
    logic [31:0] bram_rdata  [2];
    logic [AW-1:0] bram_wraddr [2];
    logic [31:0] bram_wdata  [2];
    logic [3:0]  bram_write  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] rd_s1;
        logic [31:0] rd_s2;
        logic [31:0] mem [256];

        ahblite_bram_ctrl #(
            .ADDR_WIDTH   (AW),
            .RD_LATENCY   (g + 1),
            .ERR_UNALIGNED(g == 0 ? 1 : 0)
        ) u_dut (
            .HCLK       (hclk),
            .HRESETn    (hresetn),
            .HSEL       (hsel[g]),
            .HADDR      (haddr[g]),
            .HTRANS     (htrans[g]),
            .HSIZE      (hsize[g]),
            .HPROT      (hprot[g]),
            .HWRITE     (hwrite[g]),
            .HWDATA     (hwdata[g]),
            .HREADY     (hready[g]),
            .HREADYOUT  (hreadyout[g]),
            .HRDATA     (hrdata[g]),
            .HRESP      (hresp[g]),
            .BRAM_RDADDR(bram_rdaddr[g]),
            .BRAM_RDEN  (bram_rden[g]),
            .BRAM_RDATA (bram_rdata[g]),
            .BRAM_WRADDR(bram_wraddr[g]),
            .BRAM_WDATA (bram_wdata[g]),
            .BRAM_WRITE (bram_write[g])
        );

        assign hready[g] = hreadyout[g];

        // Read-first BRAM with one or two output register stages.
        always @(posedge hclk) begin
            if (bram_rden[g]) rd_s1 <= mem[bram_rdaddr[g]];
            rd_s2 <= rd_s1;
            for (int b = 0; b < 4; b++) begin
                if (bram_write[g][b]) mem[bram_wraddr[g]][8*b +: 8] <= bram_wdata[g][8*b +: 8];
            end
        end
        assign bram_rdata[g] = (g == 0) ? rd_s1 : rd_s2;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Transfer whose data phase is currently in progress, per instance.
    bit          p_act   [2];
    bit          p_legal [2];
    bit          p_wr    [2];
    logic [31:0] p_addr  [2];
    logic [3:0]  p_lanes [2];
    logic [31:0] p_wdata [2];

    logic [31:0] ref_mem [2][64];
    logic [31:0] last_rd [2];

    function automatic bit is_legal(input logic [2:0] size, input logic [31:0] addr);
        if (size > 3'd2) return 1'b0;
        return (int'(addr[1:0]) % (1 << size)) == 0;
    endfunction

    function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [31:0] addr);
        logic [3:0] m;
        m = 4'h0;
        for (int i = 0; i < (1 << size); i++) m[int'(addr[1:0]) + i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s (dut%0d): got %h, want %h", tag, d, obs, exp);
            $error("check %s disagreed", tag);
        end
    endtask

    // Drive one address phase while completing the pending data phase.
    task automatic xfer(input int d, input bit sel, input logic [1:0] trans, input bit wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int   waits;
        int   exp_waits;
        bit   done;
        bit   acc;
        bit   lgl;
        bit   exp_resp;
        bit   exp_rden;
        waits     = 0;
        done      = 1'b0;
        acc       = sel && trans[1];
        lgl       = is_legal(size, addr);
        exp_rden  = acc && lgl && !wr;
        exp_resp  = p_act[d] && !p_legal[d] && (d == 0);
        exp_waits = (exp_resp || (p_act[d] && p_legal[d] && !p_wr[d] && d == 1)) ? 1 : 0;
        hsel[d]   = sel;
        haddr[d]  = addr;
        htrans[d] = trans;
        hsize[d]  = size;
        hwrite[d] = wr;
        hprot[d]  = 4'($urandom());
        hwdata[d] = p_wdata[d];
        while (!done) begin
            @(negedge hclk);
            chk(d, "hresp", 32'(hresp[d]), 32'(exp_resp));
            if (hreadyout[d] === 1'b1) begin
                done = 1'b1;
                chk(d, "wait_states", waits, exp_waits);
                if (p_act[d] && p_legal[d] && p_wr[d]) begin
                    chk(d, "bram_write", 32'(bram_write[d]), 32'(p_lanes[d]));
                    chk(d, "bram_wraddr", 32'(bram_wraddr[d]), 32'(p_addr[d][AW+1:2]));
                    chk(d, "bram_wdata", bram_wdata[d], p_wdata[d]);
                    for (int b = 0; b < 4; b++) begin
                        if (p_lanes[d][b]) ref_mem[d][p_addr[d][7:2]][8*b +: 8] = p_wdata[d][8*b +: 8];
                    end
                end else begin
                    chk(d, "bram_write_idle", 32'(bram_write[d]), 32'h0);
                end
                if (p_act[d] && p_legal[d] && !p_wr[d]) begin
                    chk(d, "hrdata", hrdata[d], ref_mem[d][p_addr[d][7:2]]);
                    last_rd[d] = hrdata[d];
                end
                chk(d, "bram_rden", 32'(bram_rden[d]), 32'(exp_rden));
                if (exp_rden) chk(d, "bram_rdaddr", 32'(bram_rdaddr[d]), 32'(addr[AW+1:2]));
            end else begin
                waits++;
                chk(d, "bram_write_wait", 32'(bram_write[d]), 32'h0);
                chk(d, "bram_rden_wait", 32'(bram_rden[d]), 32'h0);
                if (waits > 3) begin
                    chk(d, "wait_bound", waits, exp_waits);
                    done = 1'b1;
                end
            end
            @(posedge hclk);
            #1;
        end
        p_act[d]   = acc;
        p_legal[d] = lgl;
        p_wr[d]    = wr;
        p_addr[d]  = addr;
        p_lanes[d] = lgl ? lanes_of(size, addr) : 4'h0;
        p_wdata[d] = wdata;
    endtask

    task automatic idle(input int d);
        xfer(d, 1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    endtask

    task automatic init_mem(input int d);
        for (int w = 0; w < 64; w++) xfer(d, 1'b1, 2'b10, 1'b1, 3'd2, 32'(w * 4), $urandom());
        idle(d);
    endtask

    task automatic run_random(input int d, input int n);
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        for (int k = 0; k < n; k++) begin
            sel   = ($urandom_range(0, 9) != 0);
            trans = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr  = 32'($urandom_range(0, 31));
            xfer(d, sel, trans, wr, size, addr, $urandom());
            // A master abandons its next transfer after an error response.
            if (d == 0 && sel && trans[1] && !is_legal(size, addr)) idle(d);
        end
        idle(d);
        idle(d);
    endtask

    initial begin
        hresetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            hsel[d]    = 1'b1;
            haddr[d]   = 32'h0;
            htrans[d]  = 2'b10;
            hsize[d]   = 3'd2;
            hprot[d]   = 4'h0;
            hwrite[d]  = 1'b0;
            hwdata[d]  = 32'h0;
            p_act[d]   = 1'b0;
            p_legal[d] = 1'b0;
            p_wr[d]    = 1'b0;
            p_addr[d]  = 32'h0;
            p_lanes[d] = 4'h0;
            p_wdata[d] = 32'h0;
            last_rd[d] = 32'h0;
        end
        #7;
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_hreadyout", 32'(hreadyout[d]), 32'h1);
            chk(d, "rst_hresp", 32'(hresp[d]), 32'h0);
            chk(d, "rst_bram_write", 32'(bram_write[d]), 32'h0);
            chk(d, "rst_bram_rden", 32'(bram_rden[d]), 32'h0);
            hsel[d]   = 1'b0;
            htrans[d] = 2'b00;
        end
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Instance 0: RD_LATENCY=1, errors enabled.
        init_mem(0);
        xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        idle(0);
        chk(0, "word_wr_rd", last_rd[0], 32'hDEADBEEF);

        xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344);
        idle(0);
        xfer(0, 1'b1, 2'b10, 1'b1, 3'd0, 32'h13, 32'hAA000000);
        xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        idle(0);
        chk(0, "raw_forward", last_rd[0], 32'hAA223344);

        xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h02, 32'h55555555);
        idle(0);
        idle(0);
        xfer(0, 1'b1, 2'b01, 1'b1, 3'd2, 32'h10, 32'h66666666);
        idle(0);
        run_random(0, 80);

        // Instance 1: RD_LATENCY=2, errors disabled.
        init_mem(1);
        xfer(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        idle(1);
        xfer(1, 1'b1, 2'b10, 1'b1, 3'd2, 32'h06, 32'h77777777);
        xfer(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
        idle(1);
        xfer(1, 1'b1, 2'b10, 1'b1, 3'd1, 32'h2A, 32'h9876FFFF);
        xfer(1, 1'b1, 2'b10, 1'b0, 3'd2, 32'h28, 32'h0);
        idle(1);
        run_random(1, 80);

        // Reset while instance 0 is in the first error cycle.
        xfer(0, 1'b1, 2'b10, 1'b1, 3'd2, 32'h02, 32'h12345678);
        hsel[0]   = 1'b0;
        htrans[0] = 2'b00;
        chk(0, "err1_before_reset", 32'({hreadyout[0], hresp[0]}), 32'h1);
        hresetn = 1'b0;
        #1;
        chk(0, "reset_hresp", 32'(hresp[0]), 32'h0);
        chk(0, "reset_hreadyout", 32'(hreadyout[0]), 32'h1);
        chk(0, "reset_bram_write", 32'(bram_write[0]), 32'h0);
        for (int d = 0; d < 2; d++) p_act[d] = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        xfer(0, 1'b1, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        idle(0);
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
